// File: rtl/ofdm_tx_burst_framer_if.sv
// ofdm_tx_burst_framer_if
//   Bundles the mapper-side write port and the IFFT-side stream port of the
//   burst framer.
//   din/wren/in_ready       : upstream data words ({im,re}) and write strobe
//   dout/dout_valid/dout_ready : downstream valid/ready word stream
//   tx_done                 : one-cycle end-of-burst pulse
//   modport master : the environment (drives din, wren, dout_ready)
//   modport slave  : the framer
interface ofdm_tx_burst_framer_if;
  logic [15:0] din;
  logic        wren;
  logic        in_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        tx_done;

  modport master (
    output din, wren, dout_ready,
    input  in_ready, dout, dout_valid, tx_done
  );

  modport slave (
    input  din, wren, dout_ready,
    output in_ready, dout, dout_valid, tx_done
  );
endinterface

// File: rtl/ofdm_tx_burst_framer.sv
// ofdm_tx_burst_framer
//   Buffers one burst of SYMBOL_NUM*ACTIVE_SUBCARR data words, then streams
//   CHANNEL_EST_NUM BPSK channel-estimation symbols followed by the buffered
//   data symbols, and finishes with a one-cycle tx_done pulse.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of ofdm_tx_burst_framer_if (write port + output stream)
module ofdm_tx_burst_framer #(
  parameter int                 ACTIVE_SUBCARR  = 28,
  parameter int                 SYMBOL_NUM      = 8,
  parameter int                 CHANNEL_EST_NUM = 4,
  parameter logic [27:0]        CEST_PATTERN    = 28'hA6C_35B9,
  parameter logic signed [7:0]  CEST_AMP        = 8'sd64
) (
  input  logic                   clk,
  input  logic                   rst,
  ofdm_tx_burst_framer_if.slave  bus
);

  localparam int BUF_DEPTH  = ACTIVE_SUBCARR * SYMBOL_NUM;
  localparam int CEST_WORDS = ACTIVE_SUBCARR * CHANNEL_EST_NUM;
  localparam int TOTAL      = CEST_WORDS + BUF_DEPTH;
  localparam int WR_W       = $clog2(BUF_DEPTH + 1);
  localparam int RD_W       = $clog2(TOTAL + 1);
  localparam int SC_W       = $clog2(ACTIVE_SUBCARR);

  localparam logic [WR_W-1:0] WR_LAST   = WR_W'(BUF_DEPTH - 1);
  localparam logic [WR_W-1:0] WR_FULL   = WR_W'(BUF_DEPTH);
  localparam logic [RD_W-1:0] CEST_LAST = RD_W'(CEST_WORDS - 1);
  localparam logic [RD_W-1:0] RD_END    = RD_W'(TOTAL);
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(ACTIVE_SUBCARR - 1);

  // Negation is exact for the legal amplitude range 1..127.
  localparam logic [7:0] CEST_POS = CEST_AMP;
  localparam logic [7:0] CEST_NEG = 8'(-CEST_AMP);

  typedef enum logic [1:0] {
    LOAD,
    SEND_CEST,
    SEND_DATA,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WR_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic [RD_W-1:0] rd_cnt_reg;
  logic [SC_W-1:0] sc_reg;
  logic [WR_W-1:0] data_idx_reg, data_idx_next;
  logic [WR_W-1:0] rd_addr;
  logic [15:0]     rd_data_reg;
  logic [15:0]     dout_reg;
  logic            dout_valid_reg;
  logic            in_ready_reg;
  logic            tx_done_reg;

  logic            accept;
  logic            out_free;
  logic            xfer;
  logic            issue_cest;
  logic            issue_data;
  logic            last_xfer;

  logic [15:0] buf_mem [BUF_DEPTH];
  logic [15:0] cest_word [ACTIVE_SUBCARR];

  // Per-subcarrier channel-estimation words: {im=0, re=+/-amp}.
  for (genvar gi = 0; gi < ACTIVE_SUBCARR; gi++) begin : g_cest
    assign cest_word[gi] = CEST_PATTERN[gi] ? {8'h00, CEST_POS}
                                            : {8'h00, CEST_NEG};
  end

  // "Issue" means loading a new word into the output register; it happens
  // whenever the register is empty or its current word is being taken.
  always_comb begin
    accept     = bus.wren && in_ready_reg;
    out_free   = !dout_valid_reg || bus.dout_ready;
    xfer       = dout_valid_reg && bus.dout_ready;
    issue_cest = (state_reg == SEND_CEST) && out_free;
    issue_data = (state_reg == SEND_DATA) && out_free && (rd_cnt_reg != RD_END);
    // Every word has been issued; the burst ends when the last one leaves.
    last_xfer  = (state_reg == SEND_DATA) && xfer && (rd_cnt_reg == RD_END);
  end

  // Next-state logic. The CEST->DATA move happens when the last CEST word is
  // issued so the first data word can follow it without a bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:      if (accept && wr_cnt_reg == WR_LAST) state_next = SEND_CEST;
      SEND_CEST: if (issue_cest && rd_cnt_reg == CEST_LAST) state_next = SEND_DATA;
      SEND_DATA: if (last_xfer) state_next = DONE;
      DONE:      state_next = LOAD;
      default:   state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= LOAD;
    else     state_reg <= state_next;
  end

  // Counter next values shared by the datapath and the buffer read address.
  always_comb begin
    wr_cnt_next = wr_cnt_reg;
    if (state_reg == DONE) wr_cnt_next = '0;
    else if (accept)       wr_cnt_next = wr_cnt_reg + 1'b1;

    data_idx_next = data_idx_reg;
    if (state_reg == DONE) data_idx_next = '0;
    else if (issue_data)   data_idx_next = data_idx_reg + 1'b1;

    // Prefetch: address the word that will be issued next, so rd_data_reg
    // always holds buf_mem[data_idx_reg]. Past the end, park on 0.
    rd_addr = (data_idx_next == WR_FULL) ? '0 : data_idx_next;
  end

  // Buffer: write port in LOAD, registered read port for the prefetch.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_cnt_reg] <= bus.din;
    rd_data_reg <= buf_mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      sc_reg         <= '0;
      data_idx_reg   <= '0;
      dout_reg       <= 16'h0000;
      dout_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      tx_done_reg    <= 1'b0;
    end else begin
      wr_cnt_reg   <= wr_cnt_next;
      data_idx_reg <= data_idx_next;
      in_ready_reg <= (state_next == LOAD) && (wr_cnt_next < WR_FULL);
      tx_done_reg  <= (state_next == DONE);

      if (issue_cest) begin
        dout_reg       <= cest_word[sc_reg];
        dout_valid_reg <= 1'b1;
        rd_cnt_reg     <= rd_cnt_reg + 1'b1;
        sc_reg         <= (sc_reg == SC_LAST) ? '0 : sc_reg + 1'b1;
      end else if (issue_data) begin
        dout_reg       <= rd_data_reg;
        dout_valid_reg <= 1'b1;
        rd_cnt_reg     <= rd_cnt_reg + 1'b1;
      end else if (xfer) begin
        // Word taken with nothing left to issue; dout keeps its last value.
        dout_valid_reg <= 1'b0;
      end

      if (state_reg == DONE) begin
        rd_cnt_reg <= '0;
        sc_reg     <= '0;
      end
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.tx_done    = tx_done_reg;

endmodule

// File: tb/tb_ofdm_tx_burst_framer.sv
module tb_ofdm_tx_burst_framer;

  localparam logic [27:0] PAT = 28'hA6C35B9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy_drive = 1'b1;
  logic throttle_en = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ofdm_tx_burst_framer_if bus ();
  ofdm_tx_burst_framer_if bus2 ();

  assign bus.dout_ready  = rdy_drive;
  assign bus2.din        = bus.din;
  assign bus2.wren       = bus.wren;
  assign bus2.dout_ready = bus.dout_ready;

  ofdm_tx_burst_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ofdm_tx_burst_framer #(.CEST_AMP(8'sd127)) dut127 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_drive = throttle_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled on the falling edge, between driver updates and the
  // next rising edge where a transfer takes effect.
  logic [15:0] got[$];
  logic [15:0] got127[$];
  int          edges[$];
  int          stall_err = 0;
  int          stall_cycles = 0;
  int          done_cnt = 0;
  int          done_edge = -1;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_dout = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_cycles++;
        if (bus.dout !== stall_dout || bus.dout_valid !== 1'b1) stall_err++;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        got.push_back(bus.dout);
        got127.push_back(bus2.dout);
        edges.push_back(cyc + 1);
      end
      stall_prev = bus.dout_valid && !bus.dout_ready;
      stall_dout = bus.dout;
      if (bus.tx_done === 1'b1) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] data_word(input int kind, input int n);
    case (kind)
      0:       return 16'(32'h0100 + n);
      1:       return 16'(32'h7F80 - n);
      default: return 16'(32'h5500 + n);
    endcase
  endfunction

  function automatic logic [15:0] model_word(input int kind, input int i, input int amp);
    logic [7:0] pos;
    logic [7:0] neg;
    pos = 8'(amp);
    neg = 8'(-amp);
    if (i < 112) return PAT[i % 28] ? {8'h00, pos} : {8'h00, neg};
    return data_word(kind, i - 112);
  endfunction

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] exp;
    logic [15:0] exp127;
  } vec_t;

  vec_t vecs[$];

  task automatic write_burst(input int kind);
    for (int n = 0; n < 224; n++) begin
      int t = 0;
      while (bus.in_ready !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      bus.din  = data_word(kind, n);
      bus.wren = 1'b1;
      @(posedge clk); #1;
    end
    bus.wren = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.tx_done !== 1'b1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("tx_done_seen", 32'(bus.tx_done), 32'd1);
  endtask

  task automatic check_burst(input int kind, input int base, input string tag);
    int bad = 0;
    int bad127 = 0;
    logic [15:0] a;
    logic [15:0] b;
    check({tag, "_count"}, 32'(got.size() - base), 32'd336);
    for (int i = 0; i < 336; i++) begin
      if (base + i >= got.size()) begin
        bad++;
        bad127++;
      end else begin
        if (got[base + i] !== model_word(kind, i, 64)) bad++;
        if (got127[base + i] !== model_word(kind, i, 127)) bad127++;
      end
    end
    check({tag, "_seq_amp64_bad"}, 32'(bad), 32'd0);
    check({tag, "_seq_amp127_bad"}, 32'(bad127), 32'd0);
    foreach (vecs[k]) begin
      if (vecs[k].kind == kind) begin
        a = (base + vecs[k].idx < got.size()) ? got[base + vecs[k].idx] : 16'hDEAD;
        b = (base + vecs[k].idx < got.size()) ? got127[base + vecs[k].idx] : 16'hDEAD;
        check($sformatf("%s_word%0d", tag, vecs[k].idx), 32'(a), 32'(vecs[k].exp));
        check($sformatf("%s_word%0d_amp127", tag, vecs[k].idx), 32'(b), 32'(vecs[k].exp127));
      end
    end
  endtask

  initial begin
    int base;
    int t;

    vecs.push_back('{0, 0,   16'h0040, 16'h007F});
    vecs.push_back('{0, 1,   16'h00C0, 16'h0081});
    vecs.push_back('{0, 3,   16'h0040, 16'h007F});
    vecs.push_back('{0, 6,   16'h00C0, 16'h0081});
    vecs.push_back('{0, 27,  16'h0040, 16'h007F});
    vecs.push_back('{0, 28,  16'h0040, 16'h007F});
    vecs.push_back('{0, 29,  16'h00C0, 16'h0081});
    vecs.push_back('{0, 110, 16'h00C0, 16'h0081});
    vecs.push_back('{0, 111, 16'h0040, 16'h007F});
    vecs.push_back('{0, 112, 16'h0100, 16'h0100});
    vecs.push_back('{0, 113, 16'h0101, 16'h0101});
    vecs.push_back('{0, 200, 16'h0158, 16'h0158});
    vecs.push_back('{0, 335, 16'h01DF, 16'h01DF});
    vecs.push_back('{1, 0,   16'h0040, 16'h007F});
    vecs.push_back('{1, 19,  16'h0040, 16'h007F});
    vecs.push_back('{1, 112, 16'h7F80, 16'h7F80});
    vecs.push_back('{1, 113, 16'h7F7F, 16'h7F7F});
    vecs.push_back('{1, 335, 16'h7EA1, 16'h7EA1});
    vecs.push_back('{2, 0,   16'h0040, 16'h007F});
    vecs.push_back('{2, 16,  16'h00C0, 16'h0081});
    vecs.push_back('{2, 112, 16'h5500, 16'h5500});
    vecs.push_back('{2, 335, 16'h55DF, 16'h55DF});

    bus.din  = 16'h0;
    bus.wren = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("reset_tx_done", 32'(bus.tx_done), 32'd0);
    @(posedge clk); #1;

    // Burst 1: ready held high, late writes of FFFF while sending data.
    base = got.size();
    write_burst(0);
    check("b1_in_ready_after_E", 32'(bus.in_ready), 32'd0);
    check("b1_valid_after_E", 32'(bus.dout_valid), 32'd0);
    @(posedge clk); #1;
    check("b1_valid_after_E1", 32'(bus.dout_valid), 32'd1);
    check("b1_dout_after_E1", 32'(bus.dout), 32'h0040);
    check("b1_dout127_after_E1", 32'(bus2.dout), 32'h007F);
    repeat (130) @(posedge clk);
    #1;
    bus.din  = 16'hFFFF;
    bus.wren = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.wren = 1'b0;
    wait_done();
    check("b1_valid_at_done", 32'(bus.dout_valid), 32'd0);
    @(posedge clk); #1;
    check("b1_tx_done_cleared", 32'(bus.tx_done), 32'd0);
    check("b1_in_ready_T1", 32'(bus.in_ready), 32'd1);
    check("b1_done_cnt", 32'(done_cnt), 32'd1);
    if (got.size() >= base + 336) begin
      check("b1_contiguous_span", 32'(edges[base + 335] - edges[base] + 1), 32'd336);
      check("b1_done_after_last", 32'(done_edge), 32'(edges[base + 335]));
    end else begin
      check("b1_enough_words", 32'(got.size() - base), 32'd336);
    end
    check_burst(0, base, "b1");

    // Burst 2: starts at T+2, throttled output.
    throttle_en = 1'b1;
    base = got.size();
    write_burst(1);
    wait_done();
    check("b2_valid_at_done", 32'(bus.dout_valid), 32'd0);
    throttle_en = 1'b0;
    @(posedge clk); #1;
    check("b2_done_cnt", 32'(done_cnt), 32'd2);
    check("b2_stall_seen", 32'(stall_cycles > 0), 32'd1);
    check("b2_stall_dout_changed", 32'(stall_err), 32'd0);
    check_burst(1, base, "b2");

    // Burst 3: reset after 150 transfers, then a fresh burst.
    base = got.size();
    write_burst(0);
    t = 0;
    while (got.size() < base + 150 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("b3_reached_150", 32'(got.size() >= base + 150), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("b3_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("b3_rst_dout", 32'(bus.dout), 32'h0);
    check("b3_rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("b3_rst_tx_done", 32'(bus.tx_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("b3_no_done_after_abort", 32'(done_cnt), 32'd2);
    check("b3_idle_valid", 32'(bus.dout_valid), 32'd0);
    base = got.size();
    write_burst(2);
    wait_done();
    @(posedge clk); #1;
    check("b4_done_cnt", 32'(done_cnt), 32'd3);
    check_burst(2, base, "b4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
